// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE-754 style divider, one quotient bit per cycle.
// Denormal inputs are flushed to zero. Results that would be denormal are
// flushed to zero (underflow). Rounding is round-to-nearest-even.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (a = dividend, b = divisor)
//   out_valid / out_ready result handshake
//   result                quotient a/b
//   overflow, underflow, div_by_zero, invalid  exception flags, valid with out_valid
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         underflow,
  output logic         div_by_zero,
  output logic         invalid
);
  localparam int EW2   = EXP_W + 2;
  localparam int CNT_W = $clog2(MAN_W + 3);
  localparam logic signed [EW2-1:0] BIAS  = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EMAX  = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EZERO = '0;
  localparam logic signed [EW2-1:0] EONE  = EW2'(1);
  localparam logic [CNT_W-1:0]      CLAST = CNT_W'(MAN_W + 2);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic signed [EW2-1:0]   exp_q, exp_d;
  logic [MAN_W:0]          dvs_q, dvs_d;   // {1, fb}
  logic [MAN_W+1:0]        rem_q, rem_d;   // partial remainder, pre-shifted
  logic [MAN_W+2:0]        quo_q, quo_d;   // quo_q[MAN_W+2] has weight 2^0
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [W-1:0]            res_q, res_d;
  logic                    ovf_q, ovf_d, unf_q, unf_d, dz_q, dz_d, inv_q, inv_d;

  // operand classification
  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb;
  logic [MAN_W-1:0]  fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_inf   = (&ea) && (fa == '0);
  assign b_inf   = (&eb) && (fb == '0);
  assign a_nan   = (&ea) && (fa != '0);
  assign b_nan   = (&eb) && (fb != '0);
  assign special = a_zero | b_zero | (&ea) | (&eb);

  // restoring step
  logic             ge;
  logic [MAN_W+1:0] rem_sub;
  assign ge      = (rem_q >= {1'b0, dvs_q});
  assign rem_sub = ge ? (rem_q - {1'b0, dvs_q}) : rem_q;

  // normalise and round
  logic                  lead, grd, stk, rup;
  logic [MAN_W:0]        sig;
  logic [MAN_W+1:0]      sum;
  logic [MAN_W-1:0]      frac;
  logic signed [EW2-1:0] e1, e2;

  always_comb begin
    lead = quo_q[MAN_W+2];
    sig  = lead ? quo_q[MAN_W+2:2] : quo_q[MAN_W+1:1];
    grd  = lead ? quo_q[1] : quo_q[0];
    stk  = (lead & quo_q[0]) | (|rem_q);
    e1   = lead ? exp_q : exp_q - EONE;
    rup  = grd & (stk | sig[0]);
    sum  = {1'b0, sig} + {{(MAN_W+1){1'b0}}, rup};
    // a carry out of the significand can only produce exactly 2.0
    frac = sum[MAN_W+1] ? '0 : sum[MAN_W-1:0];
    e2   = e1 + {{(EW2-1){1'b0}}, sum[MAN_W+1]};
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    dz_d    = dz_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sign_d = sa ^ sb;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        dz_d   = 1'b0;
        inv_d  = 1'b0;
        if (special) begin
          state_d = DONE;
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res_d = QNAN;
            inv_d = 1'b1;
          end else if (a_inf) begin
            res_d = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          end else if (b_zero) begin
            res_d = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            dz_d  = 1'b1;
          end else begin
            // 0/finite or finite/inf
            res_d = {sa ^ sb, {(W-1){1'b0}}};
          end
        end else begin
          state_d = DIVIDE;
          exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
          rem_d   = {2'b01, fa};
          dvs_d   = {1'b1, fb};
          quo_d   = '0;
          cnt_d   = '0;
        end
      end
      DIVIDE: begin
        quo_d = {quo_q[MAN_W+1:0], ge};
        rem_d = {rem_sub[MAN_W:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CLAST) state_d = NORM;
      end
      NORM: begin
        state_d = DONE;
        if (e2 >= EMAX) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (e2 <= EZERO) begin
          res_d = {sign_q, {(W-1){1'b0}}};
          unf_d = 1'b1;
        end else begin
          res_d = {sign_q, e2[EXP_W-1:0], frac};
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dz_q    <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dz_q    <= dz_d;
      inv_q   <= inv_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = res_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dz_q;
  assign invalid     = inv_q;
endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8: exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23: fraction field width; word width W = 1+EXP_W+MAN_W; EXP_W=11, MAN_W=52 gives IEEE double.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands a, b present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands.
REQ-007 SHALL have port a  input  W  dividend, IEEE-754 format.
REQ-008 SHALL have port b  input  W  divisor, IEEE-754 format.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  W  quotient a/b.
REQ-012 SHALL have port overflow  output  1  result saturated to infinity.
REQ-013 SHALL have port underflow  output  1  result flushed to zero.
REQ-014 SHALL have port div_by_zero  output  1  finite nonzero divided by zero.
REQ-015 SHALL have port invalid  output  1  invalid operation, NaN result.

Function
REQ-016 SHALL implement FSM states IDLE, DIVIDE, NORM, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 SHALL accept operands on an edge with in_valid&in_ready: register a, b and sign=a.s^b.s.
REQ-018 SHALL, on acceptance, go IDLE->DONE for special operands and IDLE->DIVIDE otherwise.
REQ-019 SHALL treat exp=0 inputs as zero (flush denormals); exp all-ones with fraction 0 is inf, fraction nonzero is NaN.
REQ-020 SHALL give special results: any NaN, 0/0, inf/inf -> 0 | all-ones exp | fraction MSB 1 (canonical qNaN, sign 0), invalid=1; nonzero finite/0 -> signed inf, div_by_zero=1; inf/finite -> signed inf; 0/nonzero or finite/inf -> signed zero; no flags in the last two cases.
REQ-021 SHALL compute the biased exponent ea-eb+bias in EXP_W+2-bit signed arithmetic, bias=2^(EXP_W-1)-1.
REQ-022 SHALL run restoring division of {1,fa} by {1,fb}, one quotient bit per cycle, for exactly MAN_W+3 cycles in DIVIDE (first bit weight 2^0).
REQ-023 SHALL in NORM: if leading quotient bit 0, shift left 1 and decrement exponent; take MAN_W+1 significant bits, guard = next bit, sticky = OR(remaining bits, remainder!=0).
REQ-024 SHALL round to nearest, ties to even; a rounding carry to 2.0 renormalises and increments the exponent.
REQ-025 SHALL, after rounding, set exponent >= 2^EXP_W-1 -> signed inf, overflow=1; exponent <= 0 -> signed zero, underflow=1.
REQ-026 SHALL assert out_valid MAN_W+4 edges after the accepting edge on the divide path (27 for defaults, 56 for double) and 1 edge after on the special path.
REQ-027 SHALL hold result and all flags stable in DONE while out_ready=0; flags are meaningful only with out_valid=1.
REQ-028 SHALL go DONE->IDLE on the edge with out_ready=1; next operands are accepted no earlier than the following edge.
REQ-029 SHALL ignore in_valid and operand changes outside IDLE.

Reset
REQ-030 SHALL, on an edge with rst_n=0, enter IDLE and set result=0, out_valid=0, and all four flags=0; in_ready=1 after reset.
REQ-031 SHALL discard any operation in progress when reset is applied in DIVIDE, NORM or DONE; no out_valid follows.

Verification
REQ-032 SHALL cover: defaults, 0x3F800000/0x40000000 (1/2) -> 0x3F000000, no flags, out_valid 27 edges after accept; then 0x3F800000/0x40400000 (1/3) -> 0x3EAAAAAB.
REQ-033 SHALL cover: 0x3F800000/0x00000000 -> 0x7F800000, div_by_zero=1, latency 1; 0x00000000/0x00000000 -> 0x7FC00000, invalid=1.
REQ-034 SHALL cover: 0x7F7FFFFF/0x3E800000 (max/0.25) -> 0x7F800000 overflow=1; 0x00800000/0x40000000 (min normal/2) -> 0x00000000 underflow=1.
REQ-035 SHALL cover: EXP_W=11, MAN_W=52, 6.0/-3.0 (0x4018000000000000/0xC008000000000000) -> 0xC000000000000000, out_valid 56 edges after accept.
REQ-036 SHALL cover: out_ready=0 held 10 cycles in DONE -> result and flags unchanged; then rst_n=0 for one edge mid-DIVIDE -> IDLE, out_valid stays 0, in_ready=1.
